// File: rtl/msg_position_ctrl_if.sv
// Button/position bus for msg_position_ctrl.
// slave  : the position controller (takes the raw button, drives position/step/pressed)
// master : whoever supplies the button and consumes the message position
interface msg_position_ctrl_if;
    logic       button;
    logic [3:0] position;
    logic       step;
    logic       pressed;

    modport slave  (input  button, output position, output step, output pressed);
    modport master (output button, input  position, input  step, input  pressed);
endinterface

// File: rtl/msg_position_ctrl.sv
// msg_position_ctrl: raw push-button -> synchronised, debounced level -> wrapping
// message start position with a single-cycle step pulse per advance.
// Optional auto-repeat while the button is held is enabled by defining the
// macro MSG_POSITION_AUTO_REPEAT_EN; without it each press advances exactly once.
module msg_position_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MSG_LEN         = 16,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 12500000
) (
    input  logic                clk,
    input  logic                reset,
    msg_position_ctrl_if.slave  bus
);

    localparam int         DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] POS_MAX = 4'(MSG_LEN - 1);

    // A delay or rate of 1 would put two step pulses back to back, so both
    // are floored at 2 cycles.
    localparam int DLY_EFF  = (REPEAT_DELAY < 2) ? 2 : REPEAT_DELAY;
    localparam int RATE_EFF = (REPEAT_RATE  < 2) ? 2 : REPEAT_RATE;

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;
    logic            pressed_r;
    logic [3:0]      position_r;
    logic            step_r;
    logic [3:0]      next_pos;

`ifdef MSG_POSITION_AUTO_REPEAT_EN
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    localparam int HOLD_MAX = (DLY_EFF > RATE_EFF) ? DLY_EFF : RATE_EFF;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DLY_LAST  = HOLD_W'(DLY_EFF - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST = HOLD_W'(RATE_EFF - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    logic [HOLD_W-1:0] hold_cnt;
`else
    typedef enum logic {IDLE, HELD} state_t;

    // Repeat timing has no hardware in this build; the parameters stay on the
    // interface so both builds instantiate identically.
    if (DLY_EFF < 2 || RATE_EFF < 2) begin : g_repeat_timing_unused
    end
`endif

    state_t state;

    // Wrap back to 0 after the last message position; anything out of range
    // also returns to 0 so position can never exceed MSG_LEN-1.
    assign next_pos = (position_r >= POS_MAX) ? 4'd0 : position_r + 4'd1;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.button;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt    <= '0;
            pressed_r <= 1'b0;
        end else if (sync2 == pressed_r) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt    <= '0;
            pressed_r <= sync2;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Control FSM: one step on each accepted press, plus timed repeats when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            position_r <= 4'd0;
            step_r     <= 1'b0;
`ifdef MSG_POSITION_AUTO_REPEAT_EN
            hold_cnt   <= '0;
`endif
        end else begin
            step_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed_r) begin
                        state      <= HELD;
                        step_r     <= 1'b1;
                        position_r <= next_pos;
`ifdef MSG_POSITION_AUTO_REPEAT_EN
                        hold_cnt   <= '0;
`endif
                    end
                end
                HELD: begin
                    if (!pressed_r) begin
                        state <= IDLE;
`ifdef MSG_POSITION_AUTO_REPEAT_EN
                        hold_cnt <= '0;
                    end else if (hold_cnt == DLY_LAST) begin
                        state      <= REPEAT;
                        step_r     <= 1'b1;
                        position_r <= next_pos;
                        hold_cnt   <= '0;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
                    end
                end
`ifdef MSG_POSITION_AUTO_REPEAT_EN
                REPEAT: begin
                    if (!pressed_r) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (hold_cnt == RATE_LAST) begin
                        step_r     <= 1'b1;
                        position_r <= next_pos;
                        hold_cnt   <= '0;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.position = position_r;
    assign bus.step     = step_r;
    assign bus.pressed  = pressed_r;

endmodule
